// File: rtl/lane_packer.sv
// lane_packer: packs a stream of narrow beats into a LANES_NUM-wide lane vector.
// A vector closes on s_last or when the final lane fills. It is then held on
// the master side until it is handed off.
// Optional build macro LANE_PACKER_OVERLAP_EN: while a vector is held, s_ready
// follows m_ready, so lane 0 of the next vector is captured in the handoff
// cycle. Without the macro, each handoff costs one bubble cycle.
module lane_packer #(
    parameter int unsigned LANES_NUM   = 32,
    parameter int unsigned IDATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = $clog2(LANES_NUM + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [IDATA_WIDTH-1:0]           s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [LANES_NUM*IDATA_WIDTH-1:0] m_data,
    output logic [LANES_NUM-1:0]             m_lane_valid,
    output logic [CNT_WIDTH-1:0]             m_count
);

    localparam int unsigned MDATA_W = LANES_NUM * IDATA_WIDTH;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [MDATA_W-1:0]   data_q, data_d;
    logic [LANES_NUM-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rdy_q;

    // rdy_q keeps s_ready low during reset and raises it on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // State, lane data, lane mask and fill count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            data_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: fill lanes in order, hold the closed vector, clear on handoff
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (s_valid && rdy_q) begin
                    for (int unsigned i = 0; i < LANES_NUM; i++) begin
                        if (cnt_q == CNT_WIDTH'(i)) begin
                            data_d[i*IDATA_WIDTH +: IDATA_WIDTH] = s_data;
                            mask_d[i] = 1'b1;
                        end
                    end
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (s_last || (cnt_q == CNT_WIDTH'(LANES_NUM - 1))) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = FILL;
                    data_d  = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
`ifdef LANE_PACKER_OVERLAP_EN
                    // Beat taken in the handoff cycle opens the next vector at lane 0
                    if (s_valid && rdy_q) begin
                        data_d[IDATA_WIDTH-1:0] = s_data;
                        mask_d[0]               = 1'b1;
                        cnt_d                   = CNT_WIDTH'(1);
                        if (s_last) begin
                            state_d = HOLD;
                        end
                    end
`endif
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Upstream ready: open while filling; while holding, only in overlap builds
`ifdef LANE_PACKER_OVERLAP_EN
    assign s_ready = rdy_q && ((state_q == FILL) || m_ready);
`else
    assign s_ready = rdy_q && (state_q == FILL);
`endif

    assign m_valid      = (state_q == HOLD);
    assign m_data       = data_q;
    assign m_lane_valid = mask_q;
    assign m_count      = cnt_q;

endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer (LANES_NUM=4, IDATA_WIDTH=16): directed scenarios with
// literal expectations plus randomized traffic against a vector-level model.
module tb_lane_packer;

    localparam int unsigned LN = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;
`ifdef LANE_PACKER_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    typedef struct packed {
        logic [LN*DW-1:0] d;
        logic [LN-1:0]    m;
        logic [CW-1:0]    c;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [LN*DW-1:0] m_data;
    logic [LN-1:0]    m_lane_valid;
    logic [CW-1:0]    m_count;

    int total = 0;
    int bad   = 0;

    lane_packer #(.LANES_NUM(LN), .IDATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_lane_valid (m_lane_valid),
        .m_count      (m_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: beats collected into the open vector; closed vectors queue for output
    logic [DW-1:0] cur[$];
    vec_t          outq[$];
    bit            armed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always @(negedge clk) begin
        bit   exp_v, exp_r;
        vec_t v;
        if (!rst_n) begin
            cur.delete();
            outq.delete();
            chk("rst_s_ready", 64'(s_ready), 64'(0));
            chk("rst_m_valid", 64'(m_valid), 64'(0));
            chk("rst_m_data",  m_data, 64'(0));
            chk("rst_mask",    64'(m_lane_valid), 64'(0));
            chk("rst_count",   64'(m_count), 64'(0));
        end else begin
            exp_v = (outq.size() != 0);
            exp_r = armed && (!exp_v || (OVL && m_ready));
            chk("s_ready", 64'(s_ready), 64'(exp_r));
            chk("m_valid", 64'(m_valid), 64'(exp_v));
            if (exp_v) begin
                chk("m_data",  m_data, outq[0].d);
                chk("m_mask",  64'(m_lane_valid), 64'(outq[0].m));
                chk("m_count", 64'(m_count), 64'(outq[0].c));
            end
            if (exp_v && m_ready) void'(outq.pop_front());
            if (s_valid && exp_r) begin
                cur.push_back(s_data);
                if (s_last || cur.size() == LN) begin
                    v = '0;
                    foreach (cur[i]) begin
                        v.d[i*DW +: DW] = cur[i];
                        v.m[i] = 1'b1;
                    end
                    v.c = CW'(cur.size());
                    outq.push_back(v);
                    cur.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit got = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (s_ready) got = 1'b1;
            else step();
        end
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!got) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_valid();
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (m_valid) got = 1'b1;
        end
        if (!got) chk("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic pop();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(m_valid), 64'(0));
        chk("async_rst_data",  m_data, 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [63:0] held;
        int          bubbles;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full vector, then backpressure with s_valid pushing extra data
        send(16'h1, 1'b0); send(16'h2, 1'b0); send(16'h3, 1'b0); send(16'h4, 1'b0);
        @(negedge clk);
        chk("full_valid", 64'(m_valid), 64'(1));
        chk("full_data",  m_data, 64'h0004_0003_0002_0001);
        chk("full_mask",  64'(m_lane_valid), 64'(4'b1111));
        chk("full_count", 64'(m_count), 64'(4));
        held = m_data;
        s_valid = 1'b1; s_data = 16'hDEAD;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("bp_stable", m_data, held);
            chk("bp_ready",  64'(s_ready), 64'(0));
        end
        s_valid = 1'b0;
        step();
        pop();

        // Partial vector
        send(16'hA, 1'b0); send(16'hB, 1'b1);
        wait_valid();
        chk("part_data",  m_data, 64'h0000_0000_000B_000A);
        chk("part_mask",  64'(m_lane_valid), 64'(4'b0011));
        chk("part_count", 64'(m_count), 64'(2));
        pop();

        // s_last on the first beat
        send(16'h55, 1'b1);
        wait_valid();
        chk("one_count", 64'(m_count), 64'(1));
        chk("one_mask",  64'(m_lane_valid), 64'(4'b0001));
        pop();

        // Reset mid-vector discards the partial vector
        send(16'h11, 1'b0); send(16'h22, 1'b0);
        do_reset();
        send(16'h7, 1'b1);
        wait_valid();
        chk("rst_vec_count", 64'(m_count), 64'(1));
        chk("rst_vec_data",  m_data, 64'h0000_0000_0000_0007);
        pop();

        // s_last on lane 3 gives one vector; next beat lands in lane 0
        send(16'h1, 1'b0); send(16'h2, 1'b0); send(16'h3, 1'b0); send(16'h4, 1'b1);
        wait_valid();
        chk("l3_count", 64'(m_count), 64'(4));
        pop();
        @(negedge clk);
        chk("l3_no_extra", 64'(m_valid), 64'(0));
        step();
        send(16'h9, 1'b1);
        wait_valid();
        chk("l3_next_data", m_data, 64'h0000_0000_0000_0009);
        pop();

        // Back-to-back streaming: s_valid and m_ready held high, 4-beat vectors
        step();
        s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
        bubbles = 0;
        for (int k = 0; k < 40; k++) begin
            s_data = DW'($urandom);
            @(negedge clk);
            if (!s_ready) bubbles++;
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        chk("stream_bubbles", 64'(bubbles), OVL ? 64'(0) : 64'(8));
        step(); step(); step();
        m_ready = 1'b1; step(); step(); m_ready = 1'b0;
        do_reset();

        // Randomized traffic, including a reset in the middle
        for (int k = 0; k < 1500; k++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = DW'($urandom);
            s_last  = ($urandom_range(0, 4) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if (k == 700) rst_n = 1'b0;
            if (k == 703) rst_n = 1'b1;
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_packer.md
LANE_PACKER -- requirements
Module: lane_packer

Interface
REQ-001 SHALL have parameter LANES_NUM, default 32: lanes per packed vector; must be at least 2.
REQ-002 SHALL have parameter IDATA_WIDTH, default 16: bits per lane.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(LANES_NUM+1): width of the lane count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  upstream beat valid.
REQ-007 SHALL have port s_ready  output  1  upstream beat accepted this cycle when s_valid is also high.
REQ-008 SHALL have port s_data  input  IDATA_WIDTH  upstream beat payload.
REQ-009 SHALL have port s_last  input  1  beat closes the current vector.
REQ-010 SHALL have port m_valid  output  1  packed vector available.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the vector.
REQ-012 SHALL have port m_data  output  LANES_NUM*IDATA_WIDTH  packed lanes; lane i occupies bits [i*IDATA_WIDTH +: IDATA_WIDTH].
REQ-013 SHALL have port m_lane_valid  output  LANES_NUM  per-lane valid mask; this is the i_data_valid input of the reduction tree.
REQ-014 SHALL have port m_count  output  CNT_WIDTH  number of filled lanes, 1..LANES_NUM.

Function
REQ-015 SHALL implement two states, FILL and HOLD, and SHALL leave reset in FILL.
REQ-016 In FILL, s_ready SHALL be 1; in HOLD, s_ready SHALL be 0, except as given in REQ-027.
REQ-017 An accepted beat SHALL write s_data to lane cnt, set m_lane_valid[cnt], and increment cnt (range 0..LANES_NUM-1).
REQ-018 FILL SHALL go to HOLD on the cycle after the beat that is accepted with s_last=1 or with cnt=LANES_NUM-1; m_valid SHALL rise in that cycle (latency 1 clock).
REQ-019 In HOLD, m_valid SHALL be 1, and m_data, m_lane_valid and m_count SHALL stay stable until the cycle where m_valid and m_ready are both high.
REQ-020 On the m_valid and m_ready handshake, the block SHALL do all of the following:
- go to FILL;
- clear cnt, m_lane_valid and all m_data lanes to 0;
- drive m_valid to 0 on the next cycle.
REQ-021 Unfilled lanes SHALL read as 0 in m_data, and their m_lane_valid bits SHALL be 0.
REQ-022 s_last on the first beat SHALL produce a vector with m_count=1 and m_lane_valid=1 (bit 0 only).
REQ-023 s_last coinciding with cnt=LANES_NUM-1 SHALL produce a single full vector, not a full vector followed by an empty one.
REQ-024 In FILL, m_ready SHALL be ignored; m_valid SHALL never be high with m_count=0.

Reset
REQ-025 rst_n low SHALL, asynchronously, set the state to FILL, clear cnt, m_data, m_lane_valid and m_count, and drive m_valid to 0 and s_ready to 0.
REQ-026 Reset asserted mid-vector or during HOLD SHALL discard the partial or pending vector; after rst_n rises, s_ready SHALL be 1 from the first clock edge.

Configuration
REQ-027 Macro LANE_PACKER_OVERLAP_EN:
- Defined: in HOLD, s_ready SHALL equal m_ready. A beat accepted in the handshake cycle SHALL be written to lane 0 of the new vector, giving cnt=1 and m_lane_valid=1 (bit 0 only) on the next cycle. If that beat carries s_last=1, the state SHALL go to HOLD again instead of FILL.
- Undefined: in HOLD, s_ready SHALL be 0, so there is one bubble cycle after each handshake.

Verification
All scenarios use LANES_NUM=4 and IDATA_WIDTH=16.
REQ-028 SHALL cover full vector: beats 0x1,0x2,0x3,0x4 with m_ready=1 -> one cycle after beat 4, m_data=0x0004_0003_0002_0001, m_lane_valid=4'b1111, m_count=4.
REQ-029 SHALL cover partial vector: beats 0xA,0xB, with s_last on 0xB -> m_data=0x0000_0000_000B_000A, m_lane_valid=4'b0011, m_count=2.
REQ-030 SHALL cover backpressure: vector complete and m_ready=0 for 5 cycles -> m_valid held, outputs stable, s_ready=0, and no s_data accepted.
REQ-031 SHALL cover back-to-back streaming with s_valid held high:
- without the macro: one s_ready=0 cycle per vector;
- with LANE_PACKER_OVERLAP_EN: the next vector's lane 0 is captured in the handshake cycle, with zero bubbles.
REQ-032 SHALL cover reset mid-vector: 2 beats accepted, then rst_n pulsed low -> m_valid=0 and outputs 0; beats 0x7 with s_last then give m_count=1 and m_data lane 0 = 0x7.
REQ-033 SHALL cover s_last on lane 3 -> exactly one vector, m_count=4, and the next beat lands in lane 0.
